// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline operand selectors: FSM encoding,
// default data width and the select-width helper.
package mips_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // Select width for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sel_skid_mux_if.sv
// Channel bundle between producers, the selector and the consuming pipeline
// register. The selector uses the slave view, the environment the master view.
interface sel_skid_mux_if
    import mips_pipe_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = sel_width(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    modport slave (
        input  in_data, in_valid, sel, flush, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );

    modport master (
        output in_data, in_valid, sel, flush, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

endinterface

// File: rtl/sel_comb_mux.sv
// Combinational NUM_IN:1 word selector with an in-range flag; selects outside
// the populated channels yield zero data.
module sel_comb_mux
    import mips_pipe_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN*WIDTH-1:0]     data_i,
    input  logic [sel_width(NUM_IN)-1:0] sel_i,
    output logic [WIDTH-1:0]            data_o,
    output logic                        in_range_o
);
    localparam int SEL_W   = sel_width(NUM_IN);
    localparam int NUM_PAD = 1 << SEL_W;

    logic [WIDTH-1:0] ch_s [NUM_PAD];

    // Unused slots of the padded table read as zero so every select is defined.
    for (genvar g = 0; g < NUM_PAD; g++) begin : g_ch
        if (g < NUM_IN) begin : g_used
            assign ch_s[g] = data_i[g*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_s[g] = {WIDTH{1'b0}};
        end
    end

    assign in_range_o = (int'(sel_i) < NUM_IN);
    assign data_o     = in_range_o ? ch_s[sel_i] : {WIDTH{1'b0}};

endmodule

// File: rtl/sel_skid_mux.sv
// N:1 selector with per-channel valid/ready, a registered output word and a
// one-word skid register so consumer stalls never drop or repeat data.
module sel_skid_mux
    import mips_pipe_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sel_skid_mux_if.slave   bus
);
    localparam int SEL_W = sel_width(NUM_IN);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               out_valid_q, out_valid_d;
    logic               sel_err_q, sel_err_d;

    logic [WIDTH-1:0]   mux_data_s;
    logic               in_range_s;
    logic               ready_s;
    logic               valid_sel_s;
    logic [NUM_IN-1:0]  in_ready_s;
    logic               accept_s;
    logic               drain_s;

    sel_comb_mux #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .data_i     (bus.in_data),
        .sel_i      (bus.sel),
        .data_o     (mux_data_s),
        .in_range_o (in_range_s)
    );

    // Only the selected, in-range channel may see ready, and never while full or flushing.
    always_comb begin
        in_ready_s  = {NUM_IN{1'b0}};
        valid_sel_s = 1'b0;
        ready_s     = (state_q != ST_FULL) && !bus.flush && in_range_s;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready_s[i] = ready_s && (int'(bus.sel) == i);
            valid_sel_s   = valid_sel_s | (bus.in_valid[i] && (int'(bus.sel) == i));
        end
    end

    assign accept_s = valid_sel_s && ready_s;
    assign drain_s  = out_valid_q && bus.out_ready;

    // Next-state, data movement between skid and out registers, select error.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;
        sel_err_d  = !in_range_s && (state_q != ST_FULL) && !bus.flush;
        if (bus.flush) begin
            state_d    = ST_EMPTY;
            out_data_d = {WIDTH{1'b0}};
            skid_d     = {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d    = ST_ONE;
                        out_data_d = mux_data_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        out_data_d = mux_data_s;
                    end else if (accept_s) begin
                        state_d = ST_FULL;
                        skid_d  = mux_data_s;
                    end else if (drain_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (drain_s) begin
                        state_d    = ST_ONE;
                        out_data_d = skid_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State and datapath registers; reset discards every buffered word at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= {WIDTH{1'b0}};
            skid_q      <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_sel_skid_mux.sv
// Directed bench: a 4-channel selector driven from a vector table and a
// 3-channel selector exercising out-of-range select, plus reset corner cases.
module tb_sel_skid_mux;
    import mips_pipe_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sel_skid_mux_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
    sel_skid_mux_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

    sel_skid_mux #(.WIDTH(32), .NUM_IN(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    sel_skid_mux #(.WIDTH(32), .NUM_IN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [31:0] din;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Selected channel carries d; other channels carry a distinct poison tag.
    task automatic drive4(input logic fl, input logic [1:0] s, input logic [3:0] v,
                          input logic [31:0] d, input logic ordy);
        bus4.flush     = fl;
        bus4.sel       = s;
        bus4.in_valid  = v;
        bus4.out_ready = ordy;
        for (int i = 0; i < 4; i++)
            bus4.in_data[i*32 +: 32] = (int'(s) == i) ? d : (32'hBAD0_0000 | 32'(i));
    endtask

    task automatic drive3(input logic fl, input logic [1:0] s, input logic [2:0] v,
                          input logic [31:0] d, input logic ordy);
        bus3.flush     = fl;
        bus3.sel       = s;
        bus3.in_valid  = v;
        bus3.out_ready = ordy;
        for (int i = 0; i < 3; i++)
            bus3.in_data[i*32 +: 32] = (int'(s) == i) ? d : (32'hBAD0_0000 | 32'(i));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // streaming on channel 2
        vecs[0]  = '{1'b0, 2'd2, 4'b0100, 32'h11, 1'b1, 4'b0100, 1'b1, 32'h11};
        vecs[1]  = '{1'b0, 2'd2, 4'b0100, 32'h22, 1'b1, 4'b0100, 1'b1, 32'h22};
        vecs[2]  = '{1'b0, 2'd2, 4'b0100, 32'h33, 1'b1, 4'b0100, 1'b1, 32'h33};
        vecs[3]  = '{1'b0, 2'd2, 4'b0000, 32'h44, 1'b1, 4'b0100, 1'b0, 32'h0};
        // backpressure on channel 1, select moves while full
        vecs[4]  = '{1'b0, 2'd1, 4'b0010, 32'hA0, 1'b0, 4'b0010, 1'b1, 32'hA0};
        vecs[5]  = '{1'b0, 2'd1, 4'b0010, 32'hA1, 1'b0, 4'b0010, 1'b1, 32'hA0};
        vecs[6]  = '{1'b0, 2'd2, 4'b0100, 32'hA2, 1'b0, 4'b0000, 1'b1, 32'hA0};
        vecs[7]  = '{1'b0, 2'd1, 4'b0000, 32'hA3, 1'b1, 4'b0000, 1'b1, 32'hA1};
        vecs[8]  = '{1'b0, 2'd1, 4'b0000, 32'hA4, 1'b1, 4'b0010, 1'b0, 32'h0};
        // channel switch 0 -> 3 under stall
        vecs[9]  = '{1'b0, 2'd0, 4'b0001, 32'h5,  1'b0, 4'b0001, 1'b1, 32'h5};
        vecs[10] = '{1'b0, 2'd3, 4'b1000, 32'h7,  1'b0, 4'b1000, 1'b1, 32'h5};
        vecs[11] = '{1'b0, 2'd3, 4'b0000, 32'h8,  1'b1, 4'b0000, 1'b1, 32'h7};
        vecs[12] = '{1'b0, 2'd3, 4'b0000, 32'h9,  1'b1, 4'b1000, 1'b0, 32'h0};
        // flush from FULL with a valid input present
        vecs[13] = '{1'b0, 2'd0, 4'b0001, 32'hB0, 1'b0, 4'b0001, 1'b1, 32'hB0};
        vecs[14] = '{1'b0, 2'd0, 4'b0001, 32'hB1, 1'b0, 4'b0001, 1'b1, 32'hB0};
        vecs[15] = '{1'b1, 2'd0, 4'b0001, 32'hB2, 1'b0, 4'b0000, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 2'd0, 4'b0000, 32'hB3, 1'b1, 4'b0001, 1'b0, 32'h0};

        rst_n = 1'b0;
        drive4(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0);
        drive3(1'b0, 2'd0, 3'b000, 32'h0, 1'b0);
        #12;
        chk("rst_ov", 32'(bus4.out_valid), 32'h0);
        chk("rst_od", bus4.out_data, 32'h0);
        chk("rst_err", 32'(bus4.sel_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            drive4(vecs[k].flush, vecs[k].sel, vecs[k].vld, vecs[k].din, vecs[k].ordy);
            #1;
            chk($sformatf("v%0d_rdy", k), 32'(bus4.in_ready), 32'(vecs[k].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ov", k), 32'(bus4.out_valid), 32'(vecs[k].exp_ov));
            if (vecs[k].exp_ov)
                chk($sformatf("v%0d_od", k), bus4.out_data, vecs[k].exp_od);
            chk($sformatf("v%0d_err", k), 32'(bus4.sel_err), 32'h0);
        end

        // out-of-range select on the 3-channel instance
        @(negedge clk);
        drive4(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
        drive3(1'b0, 2'd0, 3'b001, 32'h3C, 1'b0);
        @(posedge clk); #1;
        chk("b_ov1", 32'(bus3.out_valid), 32'h1);
        chk("b_err1", 32'(bus3.sel_err), 32'h0);
        @(negedge clk);
        drive3(1'b0, 2'd3, 3'b111, 32'h3F, 1'b0);
        #1;
        chk("b_rdy", 32'(bus3.in_ready), 32'h0);
        @(posedge clk); #1;
        chk("b_err2", 32'(bus3.sel_err), 32'h1);
        chk("b_ov2", 32'(bus3.out_valid), 32'h1);
        chk("b_od2", bus3.out_data, 32'h3C);
        @(negedge clk);
        drive3(1'b0, 2'd0, 3'b001, 32'h3D, 1'b0);
        @(posedge clk); #1;
        chk("b_err3", 32'(bus3.sel_err), 32'h0);
        @(negedge clk);
        drive3(1'b0, 2'd3, 3'b111, 32'h3E, 1'b0);
        @(posedge clk); #1;
        chk("b_err_full", 32'(bus3.sel_err), 32'h0);
        chk("b_od_full", bus3.out_data, 32'h3C);
        @(negedge clk);
        drive3(1'b0, 2'd3, 3'b000, 32'h0, 1'b1);
        @(posedge clk); #1;
        chk("b_od_skid", bus3.out_data, 32'h3D);
        chk("b_err_was_full", 32'(bus3.sel_err), 32'h0);
        @(negedge clk);
        drive3(1'b0, 2'd3, 3'b000, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("b_err_one", 32'(bus3.sel_err), 32'h1);
        @(negedge clk);
        drive3(1'b1, 2'd3, 3'b111, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("b_err_flush", 32'(bus3.sel_err), 32'h0);
        chk("b_ov_flush", 32'(bus3.out_valid), 32'h0);

        // asynchronous reset while a word is held
        @(negedge clk);
        drive3(1'b0, 2'd0, 3'b000, 32'h0, 1'b0);
        drive4(1'b0, 2'd2, 4'b0100, 32'h99, 1'b0);
        @(posedge clk); #1;
        chk("r_ov_pre", 32'(bus4.out_valid), 32'h1);
        chk("r_od_pre", bus4.out_data, 32'h99);
        #1;
        rst_n = 1'b0;
        #1;
        chk("r_ov_async", 32'(bus4.out_valid), 32'h0);
        chk("r_od_async", bus4.out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive4(1'b0, 2'd2, 4'b0000, 32'h0, 1'b0);
        #1;
        chk("r_rdy_after", 32'(bus4.in_ready), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sel_skid_mux.md
Name: sel_skid_mux

Overview:
- Parametrised N:1 operand/data selector for the pipelined MIPS datapath.
- Generalises the plain 2:1 32-bit select to NUM_IN channels of WIDTH bits.
- Adds per-channel valid/ready handshaking, a one-cycle registered output and a 2-entry skid buffer, so a stall in the consumer never drops or duplicates a word.
- Sits between producer stages (ALU result, DM read data, PC+8, immediate) and a consuming pipeline register.

Parameters:
- WIDTH, 32: data width per channel.
- NUM_IN, 4: number of input channels (≥2).
- SEL_W, derived = max(1, clog2(NUM_IN)): select width. Localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready. Combinational from state and sel.
- sel  in  SEL_W  channel select, sampled every cycle.
- flush  in  1  synchronous clear of all buffered data.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts when high with out_valid.
- sel_err  out  1  registered one-cycle pulse: sel ≥ NUM_IN while that channel would be asserted.

Behaviour:
- Reset (rst_n low, async): state EMPTY; out_valid=0, out_data=0, skid data=0, sel_err=0.
- Handshake and acceptance:
  - in_ready[i]=0 for every i≠sel.
  - in_ready[sel] = (state≠FULL) && !flush && (sel<NUM_IN).
  - Accept = in_valid[sel] && in_ready[sel].
  - Drain = out_valid && out_ready.
- States:
  - EMPTY: nothing held.
  - ONE: out register valid.
  - FULL: out register + skid register valid.
- Transitions (flush low):
  - EMPTY, accept → ONE. The word is loaded into the out register.
  - ONE, accept & drain → ONE. The new word replaces the out register.
  - ONE, accept & !drain → FULL. The word goes to the skid register.
  - ONE, !accept & drain → EMPTY.
  - FULL, drain → ONE. The skid word moves to the out register. No accept is possible in FULL.
  - Otherwise hold.
- Latency and throughput:
  - 1 cycle from accept to out_valid.
  - Throughput 1 word/cycle while out_ready is held high.
- Ordering: strict FIFO order across channel switches. A word accepted from channel A before a switch to channel B is output before B's word.
- Stability: out_data and out_valid stay stable while out_valid && !out_ready.
- Flush:
  - Next state EMPTY, out_valid=0.
  - Same-cycle input is not accepted (in_ready forced 0).
  - A same-cycle drain is still counted by the consumer. The word is simply lost from this block.
  - Flush has priority over all other transitions.
- sel out of range (sel≥NUM_IN, non-power-of-2 NUM_IN only):
  - All in_ready are 0 and no accept occurs.
  - sel_err = 1 in the next cycle if state≠FULL and !flush. Otherwise sel_err = 0.
- sel changing while FULL: no effect on buffered data.
- Width rule: data passes unmodified. No sign/zero extension.
- Reset asserted mid-operation: all buffered words are discarded immediately, outputs go to reset values asynchronously.

Decomposition:
- Shared package (mips_pipe_pkg):
  - state encoding constants: EMPTY=2'b00, ONE=2'b01, FULL=2'b10.
  - default WIDTH constant (32).
- One sub-module: sel_comb_mux.
  - Purely combinational NUM_IN:1 WIDTH-bit selector; returns data and an in-range flag.
  - The top holds the FSM, skid and out registers.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 → out_valid=0 and out_data=0 the same cycle; in_ready[sel]=1 after release.
- Streaming: NUM_IN=4, sel=2, in_valid[2]=1 carrying 0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_data 0x11,0x22,0x33 one cycle later each; in_ready[0,1,3]=0 throughout.
- Backpressure: out_ready=0 after 0xA0 and 0xA1 are accepted → state FULL, in_ready[sel]=0, out_data holds 0xA0. Raise out_ready → 0xA0 then 0xA1, none lost or duplicated.
- Channel switch: accept 0x5 on ch0, then sel=3 and accept 0x7 while out_ready=0 → output order 0x5 then 0x7.
- Flush: state FULL with flush=1 and in_valid[sel]=1 → next cycle out_valid=0, no word accepted, state EMPTY.
- Bad select: NUM_IN=3, sel=3, in_valid=3'b111 → in_ready=000, sel_err=1 next cycle, out_valid unchanged.
